// File: rtl/pipe_phy_pkg.sv
// pipe_phy_pkg: PowerDown/RxStatus codes, responder FSM states and a sizing helper
// shared by the PIPE PHY responder files.
package pipe_phy_pkg;

    localparam logic [3:0] P0  = 4'd0;
    localparam logic [3:0] P0S = 4'd1;
    localparam logic [3:0] P1  = 4'd2;
    localparam logic [3:0] P2  = 4'd3;

    localparam logic [2:0] RXST_OK       = 3'b000;
    localparam logic [2:0] RXST_DETECTED = 3'b011;

    typedef enum logic [2:0] {
        ST_RESET_WAIT,
        ST_IDLE,
        ST_DETECT_WAIT,
        ST_DETECT_ACK,
        ST_DETECT_RELEASE,
        ST_PD_WAIT,
        ST_PD_ACK
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/pipe_lane_wireback.sv
// pipe_lane_wireback: one lane of the Tx-to-Rx loopback register, with electrical-idle
// gating; when disabled the lane looks idle to the MAC.
module pipe_lane_wireback #(
    parameter int W = 32
) (
    input  logic           pclk,
    input  logic           reset_n,
    input  logic           en_i,
    input  logic [W-1:0]   tx_data_i,
    input  logic [W/8-1:0] tx_k_i,
    input  logic           tx_valid_i,
    input  logic           tx_eidle_i,
    output logic [W-1:0]   rx_data_o,
    output logic [W/8-1:0] rx_k_o,
    output logic           rx_valid_o,
    output logic           rx_eidle_o
);

    logic [W-1:0]   data_q;
    logic [W/8-1:0] k_q;
    logic           valid_q;
    logic           eidle_q;
    logic           pass;

    assign pass = en_i && !tx_eidle_i;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            eidle_q <= 1'b1;
        end else begin
            data_q  <= pass ? tx_data_i : '0;
            k_q     <= en_i ? tx_k_i : '0;
            valid_q <= pass && tx_valid_i;
            eidle_q <= !en_i || tx_eidle_i;
        end
    end

    assign rx_data_o  = data_q;
    assign rx_k_o     = k_q;
    assign rx_valid_o = valid_q;
    assign rx_eidle_o = eidle_q;

endmodule

// File: rtl/pipe_phy_responder.sv
// pipe_phy_responder: PHY end of the PIPE link; handshakes reset, PowerDown and receiver
// detect with PhyStatus/RxStatus, and loops Tx back to Rx while in P0.
module pipe_phy_responder
    import pipe_phy_pkg::*;
#(
    parameter int LANESNUMBER   = 16,
    parameter int MAXPIPEWIDTH  = 32,
    parameter int RESET_CYCLES  = 8,
    parameter int DETECT_CYCLES = 4,
    parameter int PD_CYCLES     = 2
) (
    input  logic                                  pclk,
    input  logic                                  reset_n,
    input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
    input  logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] TxDataK,
    input  logic [LANESNUMBER-1:0]                TxDataValid,
    input  logic [LANESNUMBER-1:0]                TxElecIdle,
    input  logic [LANESNUMBER-1:0]                TxDetectRx_Loopback,
    input  logic [4*LANESNUMBER-1:0]              PowerDown,
    input  logic [LANESNUMBER-1:0]                RxPresent,
    output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData,
    output logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] RxDataK,
    output logic [LANESNUMBER-1:0]                RxDataValid,
    output logic [LANESNUMBER-1:0]                RxElectricalIdle,
    output logic [3*LANESNUMBER-1:0]              RxStatus,
    output logic [LANESNUMBER-1:0]                PhyStatus
);

    localparam int KW      = MAXPIPEWIDTH / 8;
    localparam int CNT_MAX = max3(RESET_CYCLES, DETECT_CYCLES, PD_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic [3:0]               pd_q;
    logic [LANESNUMBER-1:0]   det_mask_q;
    logic [LANESNUMBER-1:0]   phy_q;
    logic [3*LANESNUMBER-1:0] rxst_q;
    logic [3*LANESNUMBER-1:0] rxst_ack;
    logic [3:0]               pd_in;
    logic                     pd_chg;
    logic [LANESNUMBER-1:0]   det_req;
    logic                     wb_en;
    logic                     unused_pd;

    // All lanes carry the same PowerDown; only lane 0 is decoded.
    assign pd_in     = PowerDown[3:0];
    assign unused_pd = ^PowerDown[4*LANESNUMBER-1:4];
    assign pd_chg    = pd_in != pd_q;
    assign det_req   = TxDetectRx_Loopback & TxElecIdle;
    assign wb_en     = (pd_q == P0) && (state_q != ST_RESET_WAIT);
    assign cnt_d     = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RESET_WAIT;
            cnt_q      <= '0;
            pd_q       <= PowerDown[3:0];
            det_mask_q <= '0;
            phy_q      <= '1;
            rxst_q     <= '0;
        end else begin
            phy_q  <= '0;
            rxst_q <= '0;
            case (state_q)
                ST_RESET_WAIT: begin
                    if (cnt_d == CW'(RESET_CYCLES)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        phy_q <= '1;
                    end
                end
                ST_IDLE: begin
                    if (pd_chg) begin
                        state_q <= ST_PD_WAIT;
                        pd_q    <= pd_in;
                        cnt_q   <= '0;
                    end else if (pd_in == P1 && |det_req) begin
                        state_q    <= ST_DETECT_WAIT;
                        det_mask_q <= det_req;
                        cnt_q      <= '0;
                    end
                end
                ST_DETECT_WAIT: begin
                    if (pd_chg) begin
                        state_q <= ST_PD_WAIT;
                        pd_q    <= pd_in;
                        cnt_q   <= '0;
                    end else if (cnt_d == CW'(DETECT_CYCLES - 1)) begin
                        state_q <= ST_DETECT_ACK;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DETECT_ACK: begin
                    phy_q   <= det_mask_q;
                    rxst_q  <= rxst_ack;
                    state_q <= ST_DETECT_RELEASE;
                end
                ST_DETECT_RELEASE: begin
                    if (!(|(TxDetectRx_Loopback & det_mask_q))) state_q <= ST_IDLE;
                end
                ST_PD_WAIT: begin
                    if (pd_chg) begin
                        pd_q  <= pd_in;
                        cnt_q <= '0;
                    end else if (cnt_d == CW'(PD_CYCLES - 1)) begin
                        state_q <= ST_PD_ACK;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_PD_ACK: begin
                    phy_q   <= '1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANESNUMBER; i++) begin : g_lane
        assign rxst_ack[3*i +: 3] = (det_mask_q[i] && RxPresent[i]) ? RXST_DETECTED : RXST_OK;
        pipe_lane_wireback #(.W(MAXPIPEWIDTH)) u_wb (
            .pclk       (pclk),
            .reset_n    (reset_n),
            .en_i       (wb_en),
            .tx_data_i  (TxData[MAXPIPEWIDTH*i +: MAXPIPEWIDTH]),
            .tx_k_i     (TxDataK[KW*i +: KW]),
            .tx_valid_i (TxDataValid[i]),
            .tx_eidle_i (TxElecIdle[i]),
            .rx_data_o  (RxData[MAXPIPEWIDTH*i +: MAXPIPEWIDTH]),
            .rx_k_o     (RxDataK[KW*i +: KW]),
            .rx_valid_o (RxDataValid[i]),
            .rx_eidle_o (RxElectricalIdle[i])
        );
    end

    assign PhyStatus = phy_q;
    assign RxStatus  = rxst_q;

endmodule
